// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory bus arbiter and its access watchdog.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [2:0] {
        MARB_IDLE   = 3'd0,
        MARB_ACC_IF = 3'd1,
        MARB_ACC_RD = 3'd2,
        MARB_ACC_WR = 3'd3,
        MARB_DONE   = 3'd4
    } marb_state_t;

    localparam int MARB_TIMEOUT_CYC_DEF = 255;

    // Everything captured about the granted request in IDLE.
    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        is_data;   // 1: data port owns the access, 0: fetch port
    } marb_req_t;

    function automatic logic marb_is_acc(input marb_state_t s);
        return (s == MARB_ACC_IF) || (s == MARB_ACC_RD) || (s == MARB_ACC_WR);
    endfunction

endpackage

// File: rtl/mem_arb_wdog.sv
// Access watchdog: counts cycles spent in an ACC state, restarting from zero on entry.
// Latency: expired rises combinationally on the TIMEOUT_CYC-th ACC cycle.
// Backpressure: none; it only observes the arbiter state.
// Ports: clock/reset (async active-low), acc = arbiter is in an ACC state, expired = abort now.
module mem_arb_wdog
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = MARB_TIMEOUT_CYC_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic acc,
    output logic expired
);

    // At least 8 bits, wider if the limit needs it.
    localparam int CW = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
    // cnt_q holds the ACC cycles already completed, so the current cycle is cnt_q+1.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (acc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // The arbiter leaves ACC on expiry, so the counter never wraps.
    assign expired = acc && (cnt_q >= LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_bus_arb.sv
// Memory bus arbiter: round-robin grant of fetch and data ports onto one external bus.
// Latency: request seen in IDLE, >=1 ACC cycle until extOK, one DONE cycle with OK/Err, then IDLE.
// Backpressure: requesters hold until their OK/Err pulse; the external side stalls with extOK=0.
// Ports: clock, reset (async active-low); ifAddr/ifOE/ifData/ifOK/ifErr fetch port;
//        dAddr/dWData/dLoad/dStore/dRData/dOK/dErr data port; extAddr/extData/extOE/extWR/extOK bus.
// Option: define MEM_BUS_ARB_TIMEOUT_EN to abort accesses after TIMEOUT_CYC ACC cycles.
module mem_bus_arb
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT_CYC = MARB_TIMEOUT_CYC_DEF,
    parameter bit DATA_FIRST  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] ifAddr,
    input  logic        ifOE,
    output logic [31:0] ifData,
    output logic        ifOK,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWData,
    input  logic        dLoad,
    input  logic        dStore,
    output logic [31:0] dRData,
    output logic        dOK,
    output logic        dErr,
    output logic        ifErr,
    output logic [31:0] extAddr,
    inout  wire  [31:0] extData,
    output logic        extOE,
    output logic        extWR,
    input  logic        extOK
);

    marb_state_t state_q, state_d;
    marb_req_t   req_q, req_d;
    logic        hist_vld_q, hist_vld_d;
    logic        last_data_q, last_data_d;
    logic [31:0] if_data_q, if_data_d;
    logic [31:0] d_rdata_q, d_rdata_d;

    logic d_req;
    logic pick_data;
    logic done;
    logic timeout_hit;

    assign d_req = dLoad | dStore;

    // Data wins when alone, or on contention when fetch had the last grant
    // (or DATA_FIRST when nothing has been granted since reset).
    assign pick_data = d_req && (!ifOE || (hist_vld_q ? !last_data_q : DATA_FIRST));

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        hist_vld_d  = hist_vld_q;
        last_data_d = last_data_q;
        if_data_d   = if_data_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            MARB_IDLE: begin
                if (ifOE || d_req) begin
                    hist_vld_d    = 1'b1;
                    last_data_d   = pick_data;
                    req_d.addr    = pick_data ? dAddr : ifAddr;
                    req_d.wdata   = dWData;
                    req_d.is_data = pick_data;
                    // Load+store together is a store.
                    if (!pick_data) begin
                        state_d = MARB_ACC_IF;
                    end else if (dStore) begin
                        state_d = MARB_ACC_WR;
                    end else begin
                        state_d = MARB_ACC_RD;
                    end
                end
            end
            MARB_ACC_IF, MARB_ACC_RD, MARB_ACC_WR: begin
                // extOK takes priority over a timeout in the same cycle.
                if (extOK) begin
                    if (state_q == MARB_ACC_IF) begin
                        if_data_d = extData;
                    end
                    if (state_q == MARB_ACC_RD) begin
                        d_rdata_d = extData;
                    end
                    state_d = MARB_DONE;
                end else if (timeout_hit) begin
                    state_d = MARB_DONE;
                end
            end
            MARB_DONE: begin
                state_d = MARB_IDLE;
            end
            default: begin
                state_d = MARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= MARB_IDLE;
            req_q       <= '0;
            hist_vld_q  <= 1'b0;
            last_data_q <= 1'b0;
            if_data_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            hist_vld_q  <= hist_vld_d;
            last_data_q <= last_data_d;
            if_data_q   <= if_data_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    // All bus outputs decode the registered state, so reset forces them
    // to their idle values immediately.
    assign extOE   = (state_q == MARB_ACC_IF) || (state_q == MARB_ACC_RD);
    assign extWR   = (state_q == MARB_ACC_WR);
    assign extData = extWR ? req_q.wdata : 'z;
    assign extAddr = (state_q == MARB_IDLE) ? 32'd0 : req_q.addr;
    assign ifData  = if_data_q;
    assign dRData  = d_rdata_q;
    assign done    = (state_q == MARB_DONE);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    logic in_acc;
    logic err_q, err_d;

    assign in_acc = marb_is_acc(state_q);

    mem_arb_wdog #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_wdog (
        .clock   (clock),
        .reset   (reset),
        .acc     (in_acc),
        .expired (timeout_hit)
    );

    // Marks the following DONE cycle as an abort rather than a completion.
    always_comb begin
        err_d = in_acc && !extOK && timeout_hit;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign ifOK  = done && !req_q.is_data && !err_q;
    assign dOK   = done &&  req_q.is_data && !err_q;
    assign ifErr = done && !req_q.is_data &&  err_q;
    assign dErr  = done &&  req_q.is_data &&  err_q;
`else
    // TIMEOUT_CYC only matters when the watchdog is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYC > 0);

    assign timeout_hit = 1'b0;
    assign ifOK  = done && !req_q.is_data;
    assign dOK   = done &&  req_q.is_data;
    assign ifErr = 1'b0;
    assign dErr  = 1'b0;
`endif

endmodule

// File: tb/tb_mem_bus_arb.sv
// Randomized bench for mem_bus_arb with a transaction-level reference model.
// Latency: n/a.
// Backpressure: the memory model stalls accesses with random extOK delays.
module tb_mem_bus_arb;

    localparam bit          DATA_FIRST = 1'b1;
    localparam logic [31:0] PAT        = 32'hA5A5_5A5A;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] ifAddr, dAddr, dWData;
    logic        ifOE, dLoad, dStore, extOK;
    logic [31:0] ifData, dRData, extAddr;
    logic        ifOK, dOK, dErr, ifErr, extOE, extWR;
    wire  [31:0] extData;
    logic        mem_drv;
    logic [31:0] mem_dat;

    assign extData = mem_drv ? mem_dat : 'z;

    mem_bus_arb #(
        .TIMEOUT_CYC (4),
        .DATA_FIRST  (DATA_FIRST)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .ifAddr  (ifAddr),
        .ifOE    (ifOE),
        .ifData  (ifData),
        .ifOK    (ifOK),
        .dAddr   (dAddr),
        .dWData  (dWData),
        .dLoad   (dLoad),
        .dStore  (dStore),
        .dRData  (dRData),
        .dOK     (dOK),
        .dErr    (dErr),
        .ifErr   (ifErr),
        .extAddr (extAddr),
        .extData (extData),
        .extOE   (extOE),
        .extWR   (extWR),
        .extOK   (extOK)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    // Requester intent and reference model state.
    bit          if_pend, d_pend, d_st, d_both;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic [31:0] mdl_if, mdl_d;
    bit          grants[$];                 // 1 = data port granted
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_reqs();
        ifOE   = if_pend;
        ifAddr = if_addr;
        dStore = d_pend && d_st;
        dLoad  = d_pend && (!d_st || d_both);
        dAddr  = d_addr;
        dWData = d_wdata;
    endtask

    task automatic new_fetch();
        if_pend = 1'b1;
        if_addr = 32'h100 + ($urandom_range(0, 7) << 2);
    endtask

    task automatic new_data();
        d_pend  = 1'b1;
        d_st    = $urandom_range(0, 1) == 1;
        d_both  = d_st && ($urandom_range(0, 1) == 1);
        d_addr  = 32'h100 + ($urandom_range(0, 7) << 2);
        d_wdata = $urandom;
    endtask

    // One granted access: starts in an IDLE cycle with a request present,
    // returns #1 after the edge that brings the DUT back to IDLE.
    task automatic serve(input int delay, input bit drop_early);
        bit          win_data, is_st;
        logic [31:0] a, wd, rd;
        if (!d_pend)                win_data = 1'b0;
        else if (!if_pend)          win_data = 1'b1;
        else if (grants.size() == 0) win_data = DATA_FIRST;
        else                        win_data = !grants[$];
        is_st = win_data && d_st;
        a     = win_data ? d_addr : if_addr;
        wd    = d_wdata;
        rd    = is_st ? 32'd0 : (mem.exists(a) ? mem[a] : $urandom);

        extOK = 1'b0; mem_drv = 1'b1; mem_dat = PAT;
        @(negedge clock);
        chk("idle_oe", extOE, 1'b0);
        chk("idle_addr", extAddr, 32'd0);
        chk("idle_z", extData, PAT);
        tick();
        grants.push_back(win_data);
        if (drop_early) begin
            if (win_data) d_pend = 1'b0; else if_pend = 1'b0;
            drive_reqs();
        end
        for (int k = 0; k <= delay; k++) begin
            extOK = (k == delay); mem_drv = !is_st; mem_dat = rd;
            @(negedge clock);
            chk("acc_oe", extOE, !is_st);
            chk("acc_wr", extWR, is_st);
            chk("acc_addr", extAddr, a);
            chk("acc_nopulse", {ifOK, dOK, ifErr, dErr}, 4'd0);
            if (is_st) chk("acc_wdata", extData, wd);
            tick();
        end
        extOK = 1'b0; mem_drv = 1'b1; mem_dat = PAT;
        if (is_st) mem[a] = wd;
        else if (win_data) mdl_d = rd;
        else mdl_if = rd;
        @(negedge clock);
        chk("done_ifok", ifOK, !win_data);
        chk("done_dok", dOK, win_data);
        chk("done_err", {ifErr, dErr}, 2'd0);
        chk("done_ifdata", ifData, mdl_if);
        chk("done_drdata", dRData, mdl_d);
        chk("done_addr", extAddr, a);
        chk("done_strobes", {extOE, extWR}, 2'd0);
        tick();
    endtask

    initial begin
        bit saw;
        logic [31:0] rd;
        if_pend = 0; d_pend = 0; d_st = 0; d_both = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        mdl_if = 0; mdl_d = 0;
        extOK = 0; mem_drv = 1; mem_dat = PAT;
        drive_reqs();

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_addr", extAddr, 32'd0);
        chk("rst_ifdata", ifData, 32'd0);
        chk("rst_drdata", dRData, 32'd0);
        chk("rst_outs", {extOE, extWR, ifOK, dOK, ifErr, dErr}, 6'd0);
        chk("rst_z", extData, PAT);
        @(posedge clock); #1; reset = 1'b1;

        // Single fetch, minimum latency
        mem[32'h1000] = 32'hDEADBEEF;
        if_pend = 1; if_addr = 32'h1000; drive_reqs();
        serve(0, 1'b0);
        if_pend = 0; drive_reqs();

        // Store with extOK delayed 3 cycles
        d_pend = 1; d_st = 1; d_both = 0; d_addr = 32'h2004; d_wdata = 32'h12345678;
        drive_reqs();
        serve(3, 1'b0);
        d_pend = 0; drive_reqs();

        // Reset in the middle of a load
        d_pend = 1; d_st = 0; d_both = 0; d_addr = 32'h3000; drive_reqs();
        extOK = 0; mem_drv = 1; mem_dat = PAT;
        @(negedge clock);
        chk("mid_idle_oe", extOE, 1'b0);
        tick();
        @(negedge clock);
        chk("mid_acc_oe", extOE, 1'b1);
        chk("mid_acc_addr", extAddr, 32'h3000);
        @(posedge clock); #1;
        reset = 1'b0; d_pend = 0; drive_reqs();
        @(negedge clock);
        chk("mid_rst_addr", extAddr, 32'd0);
        chk("mid_rst_data", {ifData, dRData}, 64'd0);
        chk("mid_rst_outs", {extOE, extWR, ifOK, dOK, ifErr, dErr}, 6'd0);
        chk("mid_rst_z", extData, PAT);
        @(posedge clock); #1;
        reset = 1'b1;
        grants.delete(); mdl_if = 0; mdl_d = 0;
        @(negedge clock);
        chk("mid_no_dok", dOK, 1'b0);
        chk("mid_after_oe", extOE, 1'b0);
        tick();

        // Contention from clear history: expect data, fetch, data, fetch
        if_pend = 1; if_addr = 32'h4000;
        d_pend = 1; d_st = 0; d_both = 0; d_addr = 32'h5000;
        drive_reqs();
        for (int i = 0; i < 4; i++) serve(i % 2, 1'b0);
        if_pend = 0; d_pend = 0; drive_reqs();

        // Stalled load: aborts with the watchdog, waits forever without it
        d_pend = 1; d_st = 0; d_both = 0; d_addr = 32'h6000; drive_reqs();
        extOK = 0; mem_drv = 1; mem_dat = PAT;
        @(negedge clock);
        chk("to_idle_oe", extOE, 1'b0);
        tick();
        grants.push_back(1'b1);
`ifdef MEM_BUS_ARB_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock);
            chk("to_acc_oe", extOE, 1'b1);
            chk("to_acc_nopulse", {dOK, dErr}, 2'd0);
            tick();
        end
        d_pend = 0; drive_reqs();
        @(negedge clock);
        chk("to_derr", dErr, 1'b1);
        chk("to_dok", {dOK, ifOK, ifErr}, 3'd0);
        chk("to_drdata", dRData, mdl_d);
        tick();
`else
        saw = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (ifOK || dOK || ifErr || dErr) saw = 1'b1;
            tick();
        end
        chk("nto_nopulse", saw, 1'b0);
        rd = $urandom;
        extOK = 1; mem_dat = rd;
        @(negedge clock);
        chk("nto_acc_oe", extOE, 1'b1);
        tick();
        extOK = 0; mem_dat = PAT; mdl_d = rd;
        d_pend = 0; drive_reqs();
        @(negedge clock);
        chk("nto_dok", dOK, 1'b1);
        chk("nto_drdata", dRData, mdl_d);
        tick();
`endif

        // Random traffic
        for (int t = 0; t < 60; t++) begin
            if (!if_pend && !d_pend) begin
                @(negedge clock);
                chk("rnd_idle_oe", {extOE, extWR}, 2'd0);
                chk("rnd_idle_pulse", {ifOK, dOK, ifErr, dErr}, 4'd0);
                tick();
                case ($urandom_range(0, 2))
                    0: new_fetch();
                    1: new_data();
                    default: begin new_fetch(); new_data(); end
                endcase
                drive_reqs();
            end
            serve($urandom_range(0, 3), $urandom_range(0, 3) == 0);
            if (grants[$]) begin
                if ($urandom_range(0, 1) == 1) new_data(); else d_pend = 0;
                if (!if_pend && $urandom_range(0, 3) == 0) new_fetch();
            end else begin
                if ($urandom_range(0, 1) == 1) new_fetch(); else if_pend = 0;
                if (!d_pend && $urandom_range(0, 3) == 0) new_data();
            end
            drive_reqs();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_bus_arb.md
MEM_BUS_ARB -- requirements
Module: mem_bus_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: number of ACC-state cycles without extOK before the access is aborted.
REQ-002 SHALL have parameter DATA_FIRST, default 1: when 1, the data port wins a tie with no history; when 0, the fetch port wins.
REQ-003 SHALL have these ports, one per line (name, direction, width, meaning):
- clock  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ifAddr  in  32  fetch address.
- ifOE  in  1  fetch read request.
- ifData  out  32  fetch read data.
- ifOK  out  1  fetch completion pulse.
- dAddr  in  32  data address.
- dWData  in  32  store data.
- dLoad  in  1  load request.
- dStore  in  1  store request.
- dRData  out  32  load data.
- dOK  out  1  data completion pulse.
- dErr  out  1  data abort pulse.
- ifErr  out  1  fetch abort pulse.
- extAddr  out  32  external address.
- extData  inout  32  external data.
- extOE  out  1  external read strobe.
- extWR  out  1  external write strobe.
- extOK  in  1  external access complete.

Function
REQ-004 SHALL implement a state machine with states IDLE, ACC_IF, ACC_RD, ACC_WR and DONE.
REQ-005 In IDLE with a request pending, the arbiter SHALL latch the winner's address, store data and type, and enter the matching ACC state next cycle; with no request it SHALL stay in IDLE.
REQ-006 Arbitration SHALL be round-robin on contention: the port that did not win the last grant wins; with no history, DATA_FIRST decides.
REQ-007 If dLoad and dStore are both high, the arbiter SHALL treat the request as a store.
REQ-008 In ACC_IF and ACC_RD, extOE SHALL be 1, extWR 0, and extData high-Z.
REQ-009 In ACC_WR, extWR SHALL be 1, extOE 0, and extData driven with the latched dWData.
REQ-010 In all other states, extOE and extWR SHALL be 0 and extData high-Z.
REQ-011 extAddr SHALL hold the latched address throughout ACC and DONE, and SHALL be 0 in IDLE.
REQ-012 In an ACC state, on the cycle extOK=1, the arbiter SHALL capture extData into ifData (fetch) or dRData (load) and go to DONE.
REQ-013 ifData and dRData SHALL hold their value until the next completed read on the same port.
REQ-014 In DONE, exactly one of ifOK or dOK SHALL be 1 for exactly one cycle; the next state SHALL be IDLE; requests SHALL be ignored in DONE.
REQ-015 The requester SHALL hold its request stable until its OK or Err pulse, and SHALL deassert it or present a new request in the following cycle.
REQ-016 Minimum latency SHALL be: request seen in IDLE at cycle 0, ACC at cycle 1 with extOK=1, OK pulse at cycle 2, IDLE at cycle 3.
REQ-017 A request that drops before the arbiter reaches ACC SHALL still complete once granted; the OK pulse SHALL be issued regardless.

Reset
REQ-018 While reset=0, the block SHALL be in IDLE; extAddr, ifData and dRData SHALL be 0; all strobe, OK and Err outputs SHALL be 0; extData SHALL be high-Z; the round-robin history SHALL be cleared.
REQ-019 Reset asserted mid-access SHALL abandon the access immediately with no OK or Err pulse; after reset, operation SHALL resume from IDLE.

Configuration
REQ-020 With MEM_BUS_ARB_TIMEOUT_EN defined, an 8-bit-or-wider counter SHALL count cycles in ACC, clearing on ACC entry.
REQ-021 With MEM_BUS_ARB_TIMEOUT_EN defined, when the count reaches TIMEOUT_CYC with extOK=0, the arbiter SHALL go to DONE and pulse ifErr or dErr (instead of OK) for one cycle; read data SHALL be unchanged.
REQ-022 Without MEM_BUS_ARB_TIMEOUT_EN, ACC SHALL wait for extOK indefinitely, and ifErr and dErr SHALL be tied to 0.

Structure
REQ-023 The state encoding (MARB_IDLE, MARB_ACC_IF, MARB_ACC_RD, MARB_ACC_WR, MARB_DONE) and the TIMEOUT_CYC default SHALL live in a shared package, mem_arb_pkg.
REQ-024 The timeout counter SHALL be a sub-module, mem_arb_wdog, instantiated only under the macro; the arbiter FSM SHALL be flat.

Verification
REQ-025 Single fetch: ifOE=1, ifAddr=0x1000, extOK=1 in cycle 1 with extData=0xDEADBEEF -> extOE=1 in cycle 1; ifOK=1 and ifData=0xDEADBEEF in cycle 2.
REQ-026 Store: dStore=1, dAddr=0x2004, dWData=0x12345678, extOK delayed 3 cycles -> extWR=1 and extData=0x12345678 for 4 cycles; then one dOK pulse, and no dRData change.
REQ-027 Contention: ifOE and dLoad held high continuously, DATA_FIRST=1 -> grants alternate data, fetch, data, fetch; no port is granted twice in a row.
REQ-028 Reset mid-ACC_RD: reset=0 for 1 cycle -> all outputs 0 and extData Z that cycle; no dOK pulse; the next request is served normally.
REQ-029 Timeout (macro on, TIMEOUT_CYC=4): dLoad with extOK held 0 -> dErr pulse 5 cycles after grant; dRData unchanged. With the macro off, the bench SHALL observe no pulse after 100 cycles.
